// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a valid/ready handshake.
//   Single-cycle ops (ADD..NOT, unlisted codes, DIV by zero) finish at the
//   accept edge. MUL (signed shift-add) and DIV (signed restoring) run
//   WIDTH iterations in CALC, then one FIX cycle for sign correction.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        request handshake (in_ready only in IDLE)
//   opcode, operand_A/B      request; operand_B[SHW-1:0] is the shift amount
//   out_valid/out_ready      result handshake; result held until taken
//   result_lo/result_hi      result, MUL product halves, DIV quotient/remainder
//   flag_zero/neg/carry/ovf/dbz  status flags registered with the result
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dbz
);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6,  OP_SRA = 4'd7,  OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9,  OP_NEG = 4'd10, OP_NOT = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_DIV = 4'd13;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW:0]     WIDTH_AMT = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t            state_r, state_nx_s;
  logic              accept_s, long_op_s, load_out_s;
  logic [3:0]        op_r;
  logic [WIDTH-1:0]  acc_r, q_r, dvs_r;
  logic [SHW-1:0]    cnt_r;
  logic              sgn_lo_r, sgn_hi_r, ovf_r;

  logic [SHW-1:0]    amt_s;
  logic [SHW:0]      back_amt_s;
  logic [WIDTH:0]    sum_s;
  logic [WIDTH-1:0]  diff_s, abs_a_s, abs_b_s;
  logic [WIDTH-1:0]  sc_lo_s, sc_hi_s;
  logic              sc_c_s, sc_o_s, sc_d_s;

  logic [WIDTH:0]    mul_sum_s, div_sh_s;
  logic [WIDTH-1:0]  div_diff_s, acc_nx_s, q_nx_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]  fx_lo_s, fx_hi_s;

  logic [WIDTH-1:0]  fin_lo_s, fin_hi_s;
  logic              fin_c_s, fin_o_s, fin_d_s, fin_z_s, fin_n_s, fin_mul_s;

  assign accept_s   = in_valid & in_ready;
  assign long_op_s  = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand_B != ZERO_W));
  assign amt_s      = operand_B[SHW-1:0];
  assign back_amt_s = WIDTH_AMT - {1'b0, amt_s};
  assign sum_s      = {1'b0, operand_A} + {1'b0, operand_B};
  assign diff_s     = operand_A - operand_B;
  assign abs_a_s    = operand_A[WIDTH-1] ? (ZERO_W - operand_A) : operand_A;
  assign abs_b_s    = operand_B[WIDTH-1] ? (ZERO_W - operand_B) : operand_B;

  // Single-cycle result and flags, evaluated on the live request inputs
  always_comb begin
    sc_lo_s = ZERO_W;
    sc_hi_s = ZERO_W;
    sc_c_s  = 1'b0;
    sc_o_s  = 1'b0;
    sc_d_s  = 1'b0;
    case (opcode)
      OP_ADD: begin
        sc_lo_s = sum_s[WIDTH-1:0];
        sc_c_s  = sum_s[WIDTH];
        sc_o_s  = (operand_A[WIDTH-1] == operand_B[WIDTH-1]) &&
                  (sum_s[WIDTH-1] != operand_A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_lo_s = diff_s;
        sc_c_s  = (operand_A < operand_B);
        sc_o_s  = (operand_A[WIDTH-1] != operand_B[WIDTH-1]) &&
                  (diff_s[WIDTH-1] != operand_A[WIDTH-1]);
      end
      OP_AND: sc_lo_s = operand_A & operand_B;
      OP_OR:  sc_lo_s = operand_A | operand_B;
      OP_XOR: sc_lo_s = operand_A ^ operand_B;
      OP_SHL: sc_lo_s = operand_A << amt_s;
      OP_SHR: sc_lo_s = operand_A >> amt_s;
      OP_SRA: sc_lo_s = $signed(operand_A) >>> amt_s;
      // A shift by WIDTH yields zero, so amount 0 falls out as a pass-through
      OP_ROL: sc_lo_s = (operand_A << amt_s) | (operand_A >> back_amt_s);
      OP_ROR: sc_lo_s = (operand_A >> amt_s) | (operand_A << back_amt_s);
      OP_NEG: begin
        sc_lo_s = ZERO_W - operand_A;
        sc_o_s  = (operand_A == MIN_W);
      end
      OP_NOT: sc_lo_s = ~operand_A;
      OP_DIV: begin
        // only reaches the single-cycle path when the divisor is zero
        sc_lo_s = ONES_W;
        sc_hi_s = operand_A;
        sc_d_s  = 1'b1;
      end
      default: sc_lo_s = ZERO_W;
    endcase
  end

  // One shift-add (MUL) or restoring-subtract (DIV) iteration on magnitudes
  always_comb begin
    mul_sum_s  = {1'b0, acc_r} + (q_r[0] ? {1'b0, dvs_r} : {(WIDTH+1){1'b0}});
    div_sh_s   = {acc_r, q_r[WIDTH-1]};
    // remainder < divisor <= 2^(WIDTH-1), so the WIDTH-bit difference is exact
    div_diff_s = div_sh_s[WIDTH-1:0] - dvs_r;
    if (op_r == OP_MUL) begin
      acc_nx_s = mul_sum_s[WIDTH:1];
      q_nx_s   = {mul_sum_s[0], q_r[WIDTH-1:1]};
    end else if (div_sh_s >= {1'b0, dvs_r}) begin
      acc_nx_s = div_diff_s;
      q_nx_s   = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx_s = div_sh_s[WIDTH-1:0];
      q_nx_s   = {q_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction applied in FIX
  always_comb begin
    prod_fix_s = sgn_lo_r ? ({(2*WIDTH){1'b0}} - {acc_r, q_r}) : {acc_r, q_r};
    if (op_r == OP_MUL) begin
      fx_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fx_lo_s = prod_fix_s[WIDTH-1:0];
    end else begin
      fx_lo_s = sgn_lo_r ? (ZERO_W - q_r)   : q_r;
      fx_hi_s = sgn_hi_r ? (ZERO_W - acc_r) : acc_r;
    end
  end

  // Select the value to register and derive zero/neg from it
  always_comb begin
    if (state_r == FIX) begin
      fin_lo_s  = fx_lo_s;
      fin_hi_s  = fx_hi_s;
      fin_c_s   = 1'b0;
      fin_o_s   = ovf_r;
      fin_d_s   = 1'b0;
      fin_mul_s = (op_r == OP_MUL);
    end else begin
      fin_lo_s  = sc_lo_s;
      fin_hi_s  = sc_hi_s;
      fin_c_s   = sc_c_s;
      fin_o_s   = sc_o_s;
      fin_d_s   = sc_d_s;
      fin_mul_s = 1'b0;
    end
    fin_z_s = fin_mul_s ? ({fin_hi_s, fin_lo_s} == {(2*WIDTH){1'b0}}) : (fin_lo_s == ZERO_W);
    fin_n_s = fin_mul_s ? fin_hi_s[WIDTH-1] : fin_lo_s[WIDTH-1];
  end

  // Next-state logic and result-load strobe
  always_comb begin
    state_nx_s = state_r;
    load_out_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (long_op_s) begin
            state_nx_s = CALC;
          end else begin
            state_nx_s = DONE;
            load_out_s = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == {SHW{1'b1}}) begin
          state_nx_s = FIX;
        end else begin
          state_nx_s = CALC;
        end
      end
      FIX: begin
        state_nx_s = DONE;
        load_out_s = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register; in_ready is registered so it stays low through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      in_ready <= (state_nx_s == IDLE);
    end
  end

  // Iterative datapath: capture magnitudes at accept, iterate in CALC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 4'd0;
      acc_r    <= ZERO_W;
      q_r      <= ZERO_W;
      dvs_r    <= ZERO_W;
      cnt_r    <= {SHW{1'b0}};
      sgn_lo_r <= 1'b0;
      sgn_hi_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (accept_s) begin
      op_r     <= opcode;
      acc_r    <= ZERO_W;
      cnt_r    <= {SHW{1'b0}};
      sgn_lo_r <= operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
      if (opcode == OP_DIV) begin
        q_r      <= abs_a_s;
        dvs_r    <= abs_b_s;
        sgn_hi_r <= operand_A[WIDTH-1];
        ovf_r    <= (operand_A == MIN_W) && (operand_B == ONES_W);
      end else begin
        q_r      <= abs_b_s;
        dvs_r    <= abs_a_s;
        sgn_hi_r <= 1'b0;
        ovf_r    <= 1'b0;
      end
    end else if (state_r == CALC) begin
      acc_r <= acc_nx_s;
      q_r   <= q_nx_s;
      cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
    end
  end

  // Registered result, flags and out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result_lo  <= ZERO_W;
      result_hi  <= ZERO_W;
      flag_zero  <= 1'b0;
      flag_neg   <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      flag_dbz   <= 1'b0;
    end else if (load_out_s) begin
      out_valid  <= 1'b1;
      result_lo  <= fin_lo_s;
      result_hi  <= fin_hi_s;
      flag_zero  <= fin_z_s;
      flag_neg   <= fin_n_s;
      flag_carry <= fin_c_s;
      flag_ovf   <= fin_o_s;
      flag_dbz   <= fin_d_s;
    end else if ((state_r == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
module tb_seq_alu;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   opcode;
  logic [W-1:0] operand_A, operand_B, result_lo, result_hi;
  logic         flag_zero, flag_neg, flag_carry, flag_ovf, flag_dbz;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_A(operand_A), .operand_B(operand_B),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi),
    .flag_zero(flag_zero), .flag_neg(flag_neg), .flag_carry(flag_carry),
    .flag_ovf(flag_ovf), .flag_dbz(flag_dbz)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected values from the reference model
  logic [W-1:0] e_lo, e_hi;
  logic [4:0]   e_fl;      // {zero, neg, carry, ovf, dbz}
  int           e_lat;
  // observations from issue()
  logic [W-1:0] g_lo, g_hi;
  logic [4:0]   g_fl;
  int           g_lat;
  bit           g_rdy_low, g_stable, g_drop;

  function automatic logic [4:0] flags_now();
    return {flag_zero, flag_neg, flag_carry, flag_ovf, flag_dbz};
  endfunction

  // Reference model: plain integer arithmetic on the signed/unsigned values
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, sh;
    longint s64;
    logic [W-1:0] lo, hi, t;
    logic c, o, d, z, n;
    sa = a; sb = b; sh = int'(b[4:0]);
    lo = '0; hi = '0; c = 1'b0; o = 1'b0; d = 1'b0; e_lat = 1;
    case (op)
      4'd0: begin s64 = longint'(sa) + longint'(sb); lo = a + b;
              c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF; o = (s64 > SMAX) || (s64 < SMIN); end
      4'd1: begin s64 = longint'(sa) - longint'(sb); lo = a - b;
              c = (a < b); o = (s64 > SMAX) || (s64 < SMIN); end
      4'd2: lo = a & b;
      4'd3: lo = a | b;
      4'd4: lo = a ^ b;
      4'd5: lo = a << sh;
      4'd6: lo = a >> sh;
      4'd7: lo = 32'(sa >>> sh);
      4'd8: begin t = a; repeat (sh) t = {t[W-2:0], t[W-1]}; lo = t; end
      4'd9: begin t = a; repeat (sh) t = {t[0], t[W-1:1]}; lo = t; end
      4'd10: begin lo = 32'd0 - a; o = (a == 32'h8000_0000); end
      4'd11: lo = ~a;
      4'd12: begin s64 = longint'(sa) * longint'(sb); {hi, lo} = s64; e_lat = W + 2; end
      4'd13: begin
        if (b == 32'd0) begin
          lo = 32'hFFFF_FFFF; hi = a; d = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = a; hi = 32'd0; o = 1'b1; e_lat = W + 2;
        end else begin
          lo = 32'(sa / sb); hi = 32'(sa % sb); e_lat = W + 2;
        end
      end
      default: lo = '0;
    endcase
    z = (op == 4'd12) ? ({hi, lo} == 64'd0) : (lo == 32'd0);
    n = (op == 4'd12) ? hi[W-1] : lo[W-1];
    e_lo = lo; e_hi = hi; e_fl = {z, n, c, o, d};
  endtask

  // Drive one request, measure accept-to-valid latency, hold, then take it
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; operand_A = a; operand_B = b;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0; g_lat = -1;
      return;
    end
    @(posedge clk); #1;
    // scramble inputs: the captured request must not change
    in_valid = 1'b0; opcode = 4'($urandom); operand_A = $urandom; operand_B = $urandom;
    g_lat = 1; g_rdy_low = 1'b1;
    while (!out_valid && g_lat < 100) begin
      if (in_ready) g_rdy_low = 1'b0;
      @(posedge clk); #1; g_lat++;
    end
    if (in_ready) g_rdy_low = 1'b0;
    g_lo = result_lo; g_hi = result_hi; g_fl = flags_now();
    g_stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if ({out_valid, in_ready, result_lo, result_hi, flags_now()} !== {1'b1, 1'b0, g_lo, g_hi, g_fl})
        g_stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    g_drop = !out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; operand_A = '0; operand_B = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, result_lo, result_hi, flags_now()} !== '0) begin
      bad++; $display("FAIL reset_outputs: got rdy=%0b v=%0b lo=%h hi=%h fl=%b required all 0",
                      in_ready, out_valid, result_lo, result_hi, flags_now());
    end
    rst_n = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_early: got %0b required 0", in_ready); end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_rise: got %0b required 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [3:0]   t_op [12] = '{4'd0, 4'd1, 4'd12, 4'd13, 4'd13, 4'd13, 4'd9, 4'd7, 4'd5, 4'd15, 4'd10, 4'd8};
    logic [W-1:0] t_a  [12] = '{32'h7FFF_FFFF, 32'h3, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h5, 32'h8000_0000,
                                32'h1, 32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000, 32'h8000_0001};
    logic [W-1:0] t_b  [12] = '{32'h1, 32'h5, 32'h7, 32'h2, 32'h0, 32'hFFFF_FFFF,
                                32'h21, 32'h4, 32'h40, 32'h1, 32'h0, 32'h1};
    logic [W-1:0] t_lo [12] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'h8000_0000, 32'h8000_0000, 32'hF800_0000, 32'h1234_5678, 32'h0,
                                32'h8000_0000, 32'h0000_0003};
    logic [W-1:0] t_hi [12] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 12; i++) begin
      model(t_op[i], t_a[i], t_b[i]);
      issue(t_op[i], t_a[i], t_b[i], 0);
      total++;
      if ({g_lo, g_hi} !== {t_lo[i], t_hi[i]}) begin
        bad++; $display("FAIL dir%0d_result: got lo=%h hi=%h required lo=%h hi=%h", i, g_lo, g_hi, t_lo[i], t_hi[i]);
      end
      total++;
      if (g_fl !== e_fl) begin bad++; $display("FAIL dir%0d_flags: got %b required %b", i, g_fl, e_fl); end
      total++;
      if (g_lat !== e_lat) begin bad++; $display("FAIL dir%0d_latency: got %0d required %0d", i, g_lat, e_lat); end
      total++;
      if (!g_rdy_low || !g_drop) begin
        bad++; $display("FAIL dir%0d_handshake: rdy_low=%0b drop=%0b required 1 1", i, g_rdy_low, g_drop);
      end
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15)); a = pick(); b = pick();
      model(op, a, b);
      issue(op, a, b, $urandom_range(0, 3));
      total++;
      if ({g_lo, g_hi, g_fl} !== {e_lo, e_hi, e_fl}) begin
        bad++; $display("FAIL rnd%0d op=%0d a=%h b=%h: got lo=%h hi=%h fl=%b required lo=%h hi=%h fl=%b",
                        i, op, a, b, g_lo, g_hi, g_fl, e_lo, e_hi, e_fl);
      end
      total++;
      if ({g_lat, g_rdy_low, g_stable, g_drop} !== {e_lat, 3'b111}) begin
        bad++; $display("FAIL rnd%0d_timing: got lat=%0d rdy_low=%0b stable=%0b drop=%0b required lat=%0d 1 1 1",
                        i, g_lat, g_rdy_low, g_stable, g_drop, e_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] snap_lo, snap_hi;
    logic [4:0] snap_fl;
    model(4'd4, 32'hA5A5_0F0F, 32'h0FF0_F00F);
    @(negedge clk);
    in_valid = 1'b1; opcode = 4'd4; operand_A = 32'hA5A5_0F0F; operand_B = 32'h0FF0_F00F;
    for (int g = 0; g < 50 && !in_ready; g++) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    snap_lo = result_lo; snap_hi = result_hi; snap_fl = flags_now();
    total++;
    if ({out_valid, snap_lo, snap_hi, snap_fl} !== {1'b1, e_lo, e_hi, e_fl}) begin
      bad++; $display("FAIL bp_result: got v=%0b lo=%h hi=%h fl=%b required v=1 lo=%h hi=%h fl=%b",
                      out_valid, snap_lo, snap_hi, snap_fl, e_lo, e_hi, e_fl);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = i[0]; opcode = 4'd0; operand_A = $urandom; operand_B = $urandom;
      total++;
      if ({out_valid, in_ready, result_lo, result_hi, flags_now()} !== {1'b1, 1'b0, snap_lo, snap_hi, snap_fl}) begin
        bad++; $display("FAIL bp_hold%0d: got v=%0b rdy=%0b lo=%h required v=1 rdy=0 lo=%h",
                        i, out_valid, in_ready, result_lo, snap_lo);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: out_valid=%0b required 0", out_valid); end
    repeat (3) @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_no_accept: got v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] lo1;
    logic [4:0] fl1;
    model(4'd0, 32'h0000_1234, 32'hFFFF_F000); lo1 = e_lo; fl1 = e_fl;
    @(negedge clk);
    for (int g = 0; g < 50 && !in_ready; g++) @(negedge clk);
    in_valid = 1'b1; opcode = 4'd0; operand_A = 32'h0000_1234; operand_B = 32'hFFFF_F000; out_ready = 1'b1;
    @(posedge clk); #1;
    opcode = 4'd1; operand_A = 32'h0000_0010; operand_B = 32'h0000_0020;
    total++;
    if ({out_valid, in_ready, result_lo, flags_now()} !== {1'b1, 1'b0, lo1, fl1}) begin
      bad++; $display("FAIL b2b_first: got v=%0b rdy=%0b lo=%h fl=%b required v=1 rdy=0 lo=%h fl=%b",
                      out_valid, in_ready, result_lo, flags_now(), lo1, fl1);
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL b2b_gap: got v=%0b rdy=%0b required v=0 rdy=1", out_valid, in_ready);
    end
    model(4'd1, 32'h0000_0010, 32'h0000_0020);
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, result_lo, result_hi, flags_now()} !== {1'b1, e_lo, e_hi, e_fl}) begin
      bad++; $display("FAIL b2b_second: got v=%0b lo=%h fl=%b required v=1 lo=%h fl=%b",
                      out_valid, result_lo, flags_now(), e_lo, e_fl);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop: out_valid=%0b required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    for (int g = 0; g < 50 && !in_ready; g++) @(negedge clk);
    in_valid = 1'b1; opcode = 4'd12; operand_A = 32'h1234_5678; operand_B = 32'h0000_0003;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, result_lo, result_hi, flags_now()} !== '0) begin
      bad++; $display("FAIL midrst_outputs: got rdy=%0b v=%0b lo=%h hi=%h required all 0",
                      in_ready, out_valid, result_lo, result_hi);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %0b required 1", in_ready); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midrst_stale: out_valid cycles=%0d required 0", seen); end
    model(4'd0, 32'd2, 32'd3);
    issue(4'd0, 32'd2, 32'd3, 0);
    total++;
    if ({g_lo, g_hi, g_fl, g_lat} !== {32'd5, 32'd0, e_fl, 1}) begin
      bad++; $display("FAIL midrst_add: got lo=%h hi=%h fl=%b lat=%0d required lo=5 hi=0 fl=%b lat=1",
                      g_lo, g_hi, g_fl, g_lat, e_fl);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised multi-cycle ALU for the datapath. Successor to the 5-op combinational ALU.
- Keeps that ALU's opcode encodings 0–4 and adds shifts, rotates, negate and not.
- Adds iterative signed multiply (shift-add) and divide (restoring).
- Adds a valid/ready handshake, registered results and status flags, so the control unit can stall on long operations.

Parameters:
- WIDTH, 32, operand/result width. Must be a power of 2, at least 8.
- SHW, $clog2(WIDTH), shift-amount width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  block accepts a request this cycle
- opcode  in  4  operation select
- operand_A  in  WIDTH  first operand
- operand_B  in  WIDTH  second operand; SHW LSBs give the shift/rotate amount
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes the result
- result_lo  out  WIDTH  result; MUL low half; DIV quotient
- result_hi  out  WIDTH  MUL high half; DIV remainder; 0 for all other ops
- flag_zero  out  1  result is zero (MUL: full 2·WIDTH product)
- flag_neg  out  1  MSB of result_lo (MUL: MSB of result_hi)
- flag_carry  out  1  ADD: carry-out. SUB: 1 when A < B unsigned. 0 for other ops.
- flag_ovf  out  1  signed overflow
- flag_dbz  out  1  DIV with operand_B = 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, all outputs and internal registers 0. in_ready rises on the first cycle after release.
- Reset mid-operation: the operation is abandoned and no result is ever produced.
- Opcodes (unlisted codes 14–15 give result 0, flags 0, 1-cycle):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SHL, 6 SHR (logical), 7 SHRA (arithmetic), 8 ROL, 9 ROR
  - 10 NEG (0−A), 11 NOT (~A)
  - 12 MUL (signed), 13 DIV (signed)
- Shift/rotate amount is operand_B[SHW-1:0]; upper bits are ignored. Amount 0 passes A through unchanged.
- FSM states: IDLE, CALC, FIX, DONE.
  - in_ready = 1 only in IDLE. Acceptance = in_valid & in_ready at a rising edge.
  - Opcode and operands are captured at acceptance; later input changes have no effect.
- Single-cycle ops, and DIV by zero: IDLE→DONE at the acceptance edge. out_valid is visible 1 cycle after acceptance.
- MUL/DIV with nonzero divisor:
  - At acceptance, store operand magnitudes and result sign. IDLE→CALC, counter = 0.
  - CALC: one iteration per cycle for exactly WIDTH cycles.
  - Then FIX (one cycle) applies sign correction. FIX→DONE.
  - out_valid asserts WIDTH+2 cycles after the acceptance edge (34 for WIDTH=32).
- DONE: outputs stay stable while out_ready = 0. When out_valid & out_ready: DONE→IDLE, out_valid drops the next cycle.
  - No same-cycle re-accept; minimum issue interval is 2 cycles.
- MUL: full signed 2·WIDTH product. flag_ovf = 0.
- DIV:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN / −1: quotient = MIN, remainder = 0, flag_ovf = 1.
  - Divide by zero: quotient all-ones, remainder = A, flag_dbz = 1, result in 1 cycle.
- flag_ovf: ADD/SUB use standard two's-complement overflow. NEG sets it when A = MIN. Otherwise 0 except the DIV case above.
- flag_zero and flag_neg are computed from the final registered result for every opcode.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 → result_lo 0x80000000, ovf 1, neg 1, carry 0, zero 0. out_valid 1 cycle after accept.
- SUB 0x00000003 − 0x00000005 → result_lo 0xFFFFFFFE, carry 1, ovf 0. MUL 0xFFFFFFFD × 0x00000007 → hi 0xFFFFFFFF, lo 0xFFFFFFEB, out_valid exactly 34 cycles after accept, in_ready 0 throughout.
- DIV −7 / 2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF. DIV 5 / 0 → lo 0xFFFFFFFF, hi 5, dbz 1 after 1 cycle. DIV 0x80000000 / 0xFFFFFFFF → lo 0x80000000, hi 0, ovf 1.
- ROR 0x00000001 with B = 0x21 → 0x80000000. SHRA 0x80000000 by 4 → 0xF8000000. SHL by 0 → A unchanged. Opcode 15 → 0.
- Backpressure: hold out_ready 0 for 5 cycles after an XOR result → outputs stable, in_ready 0. Pulsing in_valid with new operands is ignored; the result is released on the first out_ready cycle.
- Drop rst_n asynchronously 10 cycles into a MUL → out_valid 0 and all outputs 0 immediately. After release, in_ready 1 and ADD 2+3 returns 5 with no stale MUL result.
